// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if -- bundles the character-write request port and the byte
// handshake to the HD44780 nibble driver.
//   slave  : the lcd_ctrl side (takes writes/clears, drives bytes to the driver)
//   master : the environment side (upstream client plus nibble driver)
// Signals:
//   wr_valid/wr_ready, wr_row, wr_col[3:0], wr_char[7:0]  character write
//   clr_req                                              clear pulse
//   ready                                                init sequence done
//   lcd_start, lcd_rs, lcd_data[7:0], lcd_busy           driver byte handshake
interface lcd_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_char;
    logic       clr_req;
    logic       ready;
    logic       lcd_start;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       lcd_busy;

    modport slave (
        input  wr_valid, wr_row, wr_col, wr_char, clr_req, lcd_busy,
        output wr_ready, ready, lcd_start, lcd_rs, lcd_data
    );

    modport master (
        output wr_valid, wr_row, wr_col, wr_char, clr_req, lcd_busy,
        input  wr_ready, ready, lcd_start, lcd_rs, lcd_data
    );
endinterface

// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- upstream sequencer for a 4-bit HD44780 nibble driver.
// Waits out LCD power-up, sends the 4-bit init byte sequence, then turns
// character writes (row/col/char) and clear pulses into command/data bytes,
// one byte per start/busy handshake with the driver.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  lcd_ctrl_if.slave (write port, clear, ready, driver handshake)
// Parameters: POWERUP_CYC, CLEAR_CYC, DISPLAY_CTRL, ENTRY_MODE.
// Optional feature: define LCD_ADDR_CACHE_EN to skip the DDRAM address byte
// when the write lands exactly where the panel cursor already is.
module lcd_ctrl #(
    parameter int unsigned POWERUP_CYC  = 480000,
    parameter int unsigned CLEAR_CYC    = 24000,
    parameter logic [7:0]  DISPLAY_CTRL = 8'h0C,
    parameter logic [7:0]  ENTRY_MODE   = 8'h06
) (
    input logic       clk,
    input logic       rst,
    lcd_ctrl_if.slave bus
);
    localparam int unsigned CNT_MAX = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [7:0]  CMD_CLEAR = 8'h01;

    localparam logic [3:0] PWR_WAIT   = 4'd0;
    localparam logic [3:0] INIT_ISSUE = 4'd1;
    localparam logic [3:0] IDLE       = 4'd2;
    localparam logic [3:0] WR_ADDR    = 4'd3;
    localparam logic [3:0] WR_CHAR    = 4'd4;
    localparam logic [3:0] CLR_ISSUE  = 4'd5;
    localparam logic [3:0] SEND       = 4'd6;
    localparam logic [3:0] WAIT_ACK   = 4'd7;
    localparam logic [3:0] WAIT_DONE  = 4'd8;
    localparam logic [3:0] POST_DELAY = 4'd9;

    logic [3:0]       state, ret_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       init_idx;
    logic             start_q, rs_q, ready_q, pend_clr;
    logic [7:0]       data_q;
    logic             row_q;
    logic [3:0]       col_q;
    logic [7:0]       char_q;
    logic             cur_row, cur_valid;
    logic [3:0]       cur_col;
    logic             wr_ready_c, clr_take, cache_miss, need_addr;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h33;
            3'd1:    return 8'h32;
            3'd2:    return 8'h28;
            3'd3:    return DISPLAY_CTRL;
            3'd4:    return CMD_CLEAR;
            default: return ENTRY_MODE;
        endcase
    endfunction

    // Writes are only taken in IDLE with nothing else owed; a clear (new or
    // pending) always wins so the write stays pending behind it.
    assign wr_ready_c = (state == IDLE) && ready_q && !bus.clr_req && !pend_clr && !bus.lcd_busy;
    assign clr_take   = (state == IDLE) && ready_q && (bus.clr_req || pend_clr) && !bus.lcd_busy;

    assign cache_miss = !cur_valid || (bus.wr_row != cur_row) || (bus.wr_col != cur_col);
`ifdef LCD_ADDR_CACHE_EN
    assign need_addr = cache_miss;
`else
    logic unused_cache;
    assign unused_cache = cache_miss;
    assign need_addr    = 1'b1;
`endif

    assign bus.wr_ready  = wr_ready_c;
    assign bus.ready     = ready_q;
    assign bus.lcd_start = start_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_data  = data_q;

    // Caller states (INIT_ISSUE, WR_ADDR, WR_CHAR, CLR_ISSUE) are re-entered
    // through ret_state once their byte has been fully sent. The first byte
    // of a write/clear is launched straight from IDLE to keep the
    // accept-to-start latency at one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PWR_WAIT;
            ret_state <= PWR_WAIT;
            cnt       <= '0;
            init_idx  <= '0;
            start_q   <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            pend_clr  <= 1'b0;
            row_q     <= 1'b0;
            col_q     <= '0;
            char_q    <= '0;
            cur_row   <= 1'b0;
            cur_col   <= '0;
            cur_valid <= 1'b0;
        end else begin
            start_q <= 1'b0;

            // Clear pulses that cannot be served right now collapse into one flag.
            if (clr_take)
                pend_clr <= 1'b0;
            else if (bus.clr_req)
                pend_clr <= 1'b1;

            case (state)
                PWR_WAIT: begin
                    if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= INIT_ISSUE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                INIT_ISSUE: begin
                    if (init_idx == 3'd6) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else if (!bus.lcd_busy) begin
                        rs_q      <= 1'b0;
                        data_q    <= init_byte(init_idx);
                        start_q   <= 1'b1;
                        init_idx  <= init_idx + 3'd1;
                        ret_state <= INIT_ISSUE;
                        state     <= SEND;
                    end
                end
                IDLE: begin
                    if (clr_take) begin
                        rs_q      <= 1'b0;
                        data_q    <= CMD_CLEAR;
                        start_q   <= 1'b1;
                        ret_state <= CLR_ISSUE;
                        state     <= SEND;
                    end else if (bus.wr_valid && wr_ready_c) begin
                        row_q   <= bus.wr_row;
                        col_q   <= bus.wr_col;
                        char_q  <= bus.wr_char;
                        start_q <= 1'b1;
                        state   <= SEND;
                        if (need_addr) begin
                            rs_q      <= 1'b0;
                            data_q    <= {1'b1, bus.wr_row, 2'b00, bus.wr_col};
                            ret_state <= WR_ADDR;
                        end else begin
                            rs_q      <= 1'b1;
                            data_q    <= bus.wr_char;
                            ret_state <= WR_CHAR;
                        end
                    end
                end
                WR_ADDR: begin
                    // Address byte done; follow with the character itself.
                    if (!bus.lcd_busy) begin
                        rs_q      <= 1'b1;
                        data_q    <= char_q;
                        start_q   <= 1'b1;
                        ret_state <= WR_CHAR;
                        state     <= SEND;
                    end
                end
                WR_CHAR: begin
                    // Panel DDRAM does not wrap at column 16, so a wrap
                    // invalidates the cursor and forces a re-address.
                    cur_row <= row_q;
                    if (col_q == 4'd15) begin
                        cur_col   <= '0;
                        cur_valid <= 1'b0;
                    end else begin
                        cur_col   <= col_q + 4'd1;
                        cur_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                CLR_ISSUE: begin
                    cur_row   <= 1'b0;
                    cur_col   <= '0;
                    cur_valid <= 1'b1;
                    state     <= IDLE;
                end
                SEND: begin
                    state <= bus.lcd_busy ? WAIT_DONE : WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.lcd_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.lcd_busy) begin
                        // Every clear command needs the long execution wait.
                        if (!rs_q && data_q == CMD_CLEAR) begin
                            cnt   <= '0;
                            state <= POST_DELAY;
                        end else begin
                            state <= ret_state;
                        end
                    end
                end
                POST_DELAY: begin
                    if (cnt == CNT_W'(CLEAR_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ret_state;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule
